// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit with the architectural HI/LO registers.
// One shift-add (MULT/MULTU) or restoring shift-subtract (DIV/DIVU) step per cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hilo_read,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] hilo_write_value,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               is_div, neg_q, neg_r, zero_div;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quot, remv, quot_fix, rem_fix;

  // Issue handshake: start is accepted only in IDLE on a posedge. While busy,
  // start/hilo_read/hi_write/lo_write are not applied and stall asks the
  // pipeline to hold the instruction and present it again next cycle.
  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_read | hi_write | lo_write);

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & operand_a[WIDTH-1];
  assign b_neg     = signed_op & operand_b[WIDTH-1];
  assign a_abs     = a_neg ? -operand_a : operand_a;
  assign b_abs     = b_neg ? -operand_b : operand_b;

  // Divide: remainder lives in acc's upper half, quotient bits enter at the bottom,
  // dividend bits are fed MSB-first out of a_reg.
  always_comb begin
    rem_shift = {acc[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, b_reg});
    rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, b_reg}) : rem_shift[WIDTH-1:0];
    div_next  = {rem_next, acc[WIDTH-2:0], q_bit};
    mul_next  = {acc[2*WIDTH-2:0], 1'b0} + (b_reg[WIDTH-1] ? {{WIDTH{1'b0}}, a_reg} : '0);
    prod_fix  = neg_q ? -acc : acc;
    quot      = acc[WIDTH-1:0];
    remv      = acc[2*WIDTH-1:WIDTH];
    quot_fix  = zero_div ? '1 : (neg_q ? -quot : quot);
    rem_fix   = neg_r ? -remv : remv;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a_abs;
            b_reg    <= b_abs;
            acc      <= '0;
            count    <= '0;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            zero_div <= op[1] & (operand_b == '0);
          end else begin
            if (hi_write) hi <= hilo_write_value;
            if (lo_write) lo <= hilo_write_value;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc   <= div_next;
            a_reg <= a_reg << 1;
          end else begin
            acc   <= mul_next;
            b_reg <= b_reg << 1;
          end
        end
        FIX: begin
          // A zero divisor leaves |a| as remainder; re-signing it restores operand_a.
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done        <= 1'b1;
          div_by_zero <= zero_div;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, stall and reset behaviour.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        hilo_read, hi_write, lo_write;
  logic [31:0] hilo_write_value;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hilo_read(hilo_read), .hi_write(hi_write), .lo_write(lo_write),
    .hilo_write_value(hilo_write_value),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one op, wait for done, check latency, busy length, results and single pulse.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                        input string tag);
    int n;
    int busy_n;
    logic [64:0] e;
    exp_q.push_back({edz, ehi, elo});
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    busy_n = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      @(negedge clock);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    e = exp_q.pop_front();
    check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(e[64]));
    @(negedge clock);
    check({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int stall_n;
    int spurious;

    reset = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hilo_read = 1'b0; hi_write = 1'b0; lo_write = 1'b0; hilo_write_value = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    reset = 1'b1;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_min");
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
    run_op(DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 1'b0, "divu");
    run_op(DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1, "div_zero");
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
    run_op(DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_zero_neg");

    // Stall behaviour: MULTU 5*6 with a read, a second start and mthi during RUN.
    @(negedge clock);
    start = 1'b1; op = MULTU; operand_a = 32'd5; operand_b = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    hilo_read = 1'b1;
    #1 check("stall_read", 64'(stall), 64'd1);
    start = 1'b1; op = DIVU; operand_a = 32'd100; operand_b = 32'd7;
    hi_write = 1'b1; hilo_write_value = 32'hDEAD_BEEF;
    #1 check("stall_start_mthi", 64'(stall), 64'd1);
    repeat (3) @(negedge clock);
    start = 1'b0; hi_write = 1'b0;
    check("mthi_blocked", 64'(hi), 64'hFFFF_FFF9);
    n = 0;
    stall_n = 0;
    while (!done && n < 100) begin
      if (stall) stall_n++;
      @(negedge clock);
      n++;
    end
    check("stall_cycles", 64'(stall_n), 64'd25);
    check("stall_done_cycle", 64'(stall), 64'd0);
    check("mid_start_hi", 64'(hi), 64'd0);
    check("mid_start_lo", 64'(lo), 64'd30);
    hilo_read = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) spurious++;
    end
    check("no_extra_op", 64'(spurious), 64'd0);

    // Reset in the middle of RUN discards the operation.
    @(negedge clock);
    start = 1'b1; op = MULTU; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    reset = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) spurious++;
    end
    check("midrst_no_done", 64'(spurious), 64'd0);

    lo_write = 1'b1; hilo_write_value = 32'h55;
    @(negedge clock);
    lo_write = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h55);
    check("mtlo_hi", 64'(hi), 64'd0);

    run_op(MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, "multu_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
